// File: rtl/instr_encoder_pkg.sv
// Shared encodings for the instruction encoder: request classes, ALU control
// codes, data-processing opcodes, FSM state and 32-bit word field positions.
package instr_encoder_pkg;

    localparam logic [1:0] CLASS_DP  = 2'b00;
    localparam logic [1:0] CLASS_MEM = 2'b01;
    localparam logic [1:0] CLASS_BR  = 2'b10;
    localparam logic [1:0] CLASS_ILL = 2'b11;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_AND = 4'b0100;
    localparam logic [3:0] ALU_ORR = 4'b0101;
    localparam logic [3:0] ALU_EOR = 4'b0110;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_EOR = 4'b0001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10,
        ST_ERR  = 2'b11
    } state_t;

    localparam int COND_LSB = 28;
    localparam int OP_LSB   = 26;
    localparam int I_BIT    = 25;
    localparam int CMD_LSB  = 21;
    localparam int S_BIT    = 20;
    localparam int RN_LSB   = 16;
    localparam int RD_LSB   = 12;
    localparam int P_BIT    = 24;
    localparam int U_BIT    = 23;
    localparam int B_BIT    = 22;
    localparam int W_BIT    = 21;
    localparam int L_BIT    = 20;
    localparam int BR_LSB   = 24;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] BR_NOLINK = 2'b10;

    // Returns {supported, cmd} for an ALU control code.
    function automatic logic [4:0] dp_cmd(input logic [3:0] aluop);
        case (aluop)
            ALU_ADD: dp_cmd = {1'b1, CMD_ADD};
            ALU_SUB: dp_cmd = {1'b1, CMD_SUB};
            ALU_AND: dp_cmd = {1'b1, CMD_AND};
            ALU_ORR: dp_cmd = {1'b1, CMD_ORR};
            ALU_EOR: dp_cmd = {1'b1, CMD_EOR};
            default: dp_cmd = {1'b0, 4'b0000};
        endcase
    endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational packer: turns one request's fields into its 32-bit machine
// word and flags requests that have no legal encoding.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [1:0]  in_class,
    input  logic [3:0]  in_cond,
    input  logic [3:0]  in_aluop,
    input  logic        in_s,
    input  logic        in_imm,
    input  logic        in_load,
    input  logic        in_byte,
    input  logic [3:0]  in_rd,
    input  logic [3:0]  in_rn,
    input  logic [23:0] in_operand,
    output logic [31:0] word,
    output logic        illegal
);

    logic [4:0] cmd_lookup;

    assign cmd_lookup = dp_cmd(in_aluop);

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        word[COND_LSB +: 4] = in_cond;
        case (in_class)
            CLASS_DP: begin
                illegal             = ~cmd_lookup[4];
                word[OP_LSB +: 2]   = OP_DP;
                word[I_BIT]         = in_imm;
                word[CMD_LSB +: 4]  = cmd_lookup[3:0];
                word[S_BIT]         = in_s;
                word[RN_LSB +: 4]   = in_rn;
                word[RD_LSB +: 4]   = in_rd;
                word[11:0]          = in_imm ? {4'b0000, in_operand[7:0]}
                                             : {8'b0000_0000, in_operand[3:0]};
            end
            CLASS_MEM: begin
                // Pre-indexed, offset added, no write-back, immediate offset.
                word[OP_LSB +: 2]   = OP_MEM;
                word[I_BIT]         = 1'b0;
                word[P_BIT]         = 1'b1;
                word[U_BIT]         = 1'b1;
                word[B_BIT]         = in_byte;
                word[W_BIT]         = 1'b0;
                word[L_BIT]         = in_load;
                word[RN_LSB +: 4]   = in_rn;
                word[RD_LSB +: 4]   = in_rd;
                word[11:0]          = in_operand[11:0];
            end
            CLASS_BR: begin
                word[OP_LSB +: 2]   = OP_BR;
                word[BR_LSB +: 2]   = BR_NOLINK;
                word[23:0]          = in_operand;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts encode requests, packs them into 32-bit words
// and writes them sequentially into instruction memory, tracking done/error.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    in_class,
    input  logic [3:0]    in_cond,
    input  logic [3:0]    in_aluop,
    input  logic          in_s,
    input  logic          in_imm,
    input  logic          in_load,
    input  logic          in_byte,
    input  logic [3:0]    in_rd,
    input  logic [3:0]    in_rn,
    input  logic [23:0]   in_operand,
    input  logic          in_last,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic          mem_ready,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW:0]   count,
    output state_t        state
);

    // Handshake: a request transfers on a rising edge where in_valid and
    // in_ready are both high; a memory write completes on an edge where
    // mem_we and mem_ready are both high, and mem_* hold until then.

    state_t      state_d;
    logic [31:0] word;
    logic        illegal;
    logic        pend_last;
    logic        accept;
    logic        complete;
    logic        full;

    instr_pack u_pack (
        .in_class   (in_class),
        .in_cond    (in_cond),
        .in_aluop   (in_aluop),
        .in_s       (in_s),
        .in_imm     (in_imm),
        .in_load    (in_load),
        .in_byte    (in_byte),
        .in_rd      (in_rd),
        .in_rn      (in_rn),
        .in_operand (in_operand),
        .word       (word),
        .illegal    (illegal)
    );

    // Full also covers a pending write that ends the memory or the program,
    // so no further request can slip in behind it.
    assign full     = count[AW] | (mem_we & (&mem_addr)) | (mem_we & pend_last);
    assign accept   = in_valid & in_ready;
    assign complete = mem_we & mem_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        if (start) begin
            state_d = ST_RUN;
        end else if (state == ST_RUN) begin
            if (accept && illegal) begin
                state_d = ST_ERR;
            end else if (complete && pend_last) begin
                state_d = ST_DONE;
            end else if (complete && (&mem_addr)) begin
                state_d = ST_ERR;
            end
        end
    end

    always_comb begin
        in_ready = (state == ST_RUN) & ~start & (~mem_we | mem_ready) & ~full;
        busy     = (state == ST_RUN) | mem_we;
        done     = (state == ST_DONE);
        err      = (state == ST_ERR);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            count     <= '0;
            pend_last <= 1'b0;
        end else if (start) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            count     <= '0;
            pend_last <= 1'b0;
        end else begin
            if (complete) begin
                mem_addr <= mem_addr + {{(AW-1){1'b0}}, 1'b1};
                count    <= count + {{AW{1'b0}}, 1'b1};
            end
            if (accept && !illegal) begin
                mem_we    <= 1'b1;
                mem_wdata <= word;
                pend_last <= in_last;
            end else if (complete) begin
                mem_we    <= 1'b0;
                pend_last <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus randomized
// programs, with a write scoreboard fed from an instruction-level model.
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_class;
    logic [3:0]    in_cond;
    logic [3:0]    in_aluop;
    logic          in_s;
    logic          in_imm;
    logic          in_load;
    logic          in_byte;
    logic [3:0]    in_rd;
    logic [3:0]    in_rn;
    logic [23:0]   in_operand;
    logic          in_last;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_ready;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW:0]   count;
    state_t        state;

    int n_tests = 0;
    int n_fail  = 0;
    int model_ptr = 0;
    bit rand_ready = 1'b0;
    logic [AW+31:0] exp_q[$];
    logic [3:0] legal_ops [5] = '{4'b0000, 4'b0010, 4'b0100, 4'b0101, 4'b0110};

    instr_encoder #(.AW(AW)) u_dut (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_class(in_class), .in_cond(in_cond), .in_aluop(in_aluop),
        .in_s(in_s), .in_imm(in_imm), .in_load(in_load), .in_byte(in_byte),
        .in_rd(in_rd), .in_rn(in_rn), .in_operand(in_operand), .in_last(in_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .busy(busy), .done(done), .err(err),
        .count(count), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference encoding built from the field rules: {illegal, word}.
    function automatic logic [32:0] model(input logic [1:0] c, input logic [3:0] cond,
            input logic [3:0] aluop, input logic s, input logic imm, input logic load,
            input logic byt, input logic [3:0] rd, input logic [3:0] rn, input logic [23:0] op);
        logic [31:0] w;
        logic [31:0] cmd;
        logic        ill;
        ill = 1'b0;
        cmd = 0;
        w   = 32'(cond) * (2 ** 28);
        case (c)
            2'd0: begin
                case (aluop)
                    4'd0: cmd = 4;
                    4'd2: cmd = 2;
                    4'd4: cmd = 0;
                    4'd5: cmd = 12;
                    4'd6: cmd = 1;
                    default: ill = 1'b1;
                endcase
                w = w + 32'(imm) * (2 ** 25) + cmd * (2 ** 21) + 32'(s) * (2 ** 20)
                      + 32'(rn) * (2 ** 16) + 32'(rd) * (2 ** 12)
                      + (imm ? 32'(op) % 256 : 32'(op) % 16);
            end
            2'd1: w = w + 32'h0400_0000 + 32'h0100_0000 + 32'h0080_0000
                      + 32'(byt) * (2 ** 22) + 32'(load) * (2 ** 20)
                      + 32'(rn) * (2 ** 16) + 32'(rd) * (2 ** 12) + 32'(op) % 4096;
            2'd2: w = w + 32'h0A00_0000 + 32'(op);
            default: ill = 1'b1;
        endcase
        return {ill, (ill ? 32'h0 : w)};
    endfunction

    // Monitor: every completed memory write must match the next expected one.
    always @(negedge clk) begin
        logic [AW+31:0] e;
        if (reset === 1'b1 && mem_we === 1'b1 && mem_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected none", mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", 32'(mem_addr), 32'(e[AW+31:32]));
                check("write_data", mem_wdata, e[31:0]);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) mem_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic set_ready(input logic v);
        rand_ready = 1'b0;
        @(posedge clk);
        #1 mem_ready = v;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        exp_q.delete();
        model_ptr = 0;
    endtask

    task automatic send_req(input logic [1:0] c, input logic [3:0] cond, input logic [3:0] aluop,
            input logic s, input logic imm, input logic load, input logic byt,
            input logic [3:0] rd, input logic [3:0] rn, input logic [23:0] op, input logic last);
        logic [32:0] r;
        int waited;
        @(posedge clk);
        #1;
        in_class = c; in_cond = cond; in_aluop = aluop; in_s = s; in_imm = imm;
        in_load = load; in_byte = byt; in_rd = rd; in_rn = rn; in_operand = op;
        in_last = last; in_valid = 1'b1;
        waited = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (in_ready !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready %b, expected 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        r = model(c, cond, aluop, s, imm, load, byt, rd, rn, op);
        @(posedge clk);
        #1 in_valid = 1'b0;
        if (!r[32]) begin
            exp_q.push_back({model_ptr[AW-1:0], r[31:0]});
            model_ptr++;
        end
        @(negedge clk);
        check("latency_we", 32'(mem_we), 32'(!r[32]));
        if (!r[32]) check("latency_data", mem_wdata, r[31:0]);
    endtask

    task automatic wait_state(input state_t target, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (state !== target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_state", 32'(state), 32'(target));
    endtask

    task automatic send_random(input logic last);
        send_req(2'($urandom_range(0, 2)), 4'($urandom), legal_ops[$urandom_range(0, 4)],
                 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 4'($urandom), 4'($urandom), 24'($urandom), last);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"}, 32'(mem_we), 0);
        check({tag, "_addr"}, 32'(mem_addr), 0);
        check({tag, "_wdata"}, mem_wdata, 0);
        check({tag, "_count"}, 32'(count), 0);
        check({tag, "_ready"}, 32'(in_ready), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_err"}, 32'(err), 0);
        check({tag, "_state"}, 32'(state), 32'(ST_IDLE));
    endtask

    initial begin
        logic [AW-1:0] hold_addr;
        logic [31:0]   hold_data;
        int            n;

        reset = 1'b0; start = 1'b0; in_valid = 1'b0; mem_ready = 1'b0;
        in_class = '0; in_cond = '0; in_aluop = '0; in_s = 1'b0; in_imm = 1'b0;
        in_load = 1'b0; in_byte = 1'b0; in_rd = '0; in_rn = '0; in_operand = '0;
        in_last = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 reset = 1'b1;

        // ADD with immediate, single-word program
        set_ready(1'b1);
        pulse_start();
        send_req(2'b00, 4'hE, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 4'd1, 24'h000005, 1'b1);
        wait_state(ST_DONE, 20);
        check("add_done", 32'(done), 1);
        check("add_count", 32'(count), 1);
        check("add_word", 32'(model(2'b00, 4'hE, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0,
                                    4'd2, 4'd1, 24'h5)), 32'hE291_2005);

        // LDRB then STR
        pulse_start();
        send_req(2'b01, 4'hE, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd4, 4'd3, 24'h000010, 1'b0);
        send_req(2'b01, 4'hE, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4, 4'd3, 24'h000010, 1'b1);
        wait_state(ST_DONE, 20);
        check("mem_count", 32'(count), 2);

        // Branch with a three-cycle memory stall
        set_ready(1'b0);
        pulse_start();
        send_req(2'b10, 4'h1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 24'hFFFFFE, 1'b1);
        hold_addr = mem_addr;
        hold_data = mem_wdata;
        check("stall_data", hold_data, 32'h1AFF_FFFE);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            check("stall_we", 32'(mem_we), 1);
            check("stall_addr", 32'(mem_addr), 32'(hold_addr));
            check("stall_wdata", mem_wdata, hold_data);
            check("stall_ready", 32'(in_ready), 0);
        end
        @(posedge clk);
        #1 mem_ready = 1'b1;
        wait_state(ST_DONE, 20);
        check("stall_count", 32'(count), 1);

        // Overflow: fill all 2**AW words without a last marker
        pulse_start();
        for (int i = 0; i < 4; i++) send_random(1'b0);
        wait_state(ST_ERR, 20);
        check("ovf_err", 32'(err), 1);
        check("ovf_ready", 32'(in_ready), 0);
        check("ovf_count", 32'(count), 4);
        check("ovf_queue", 32'(exp_q.size()), 0);

        // Unsupported ALU control code, then recovery by start
        pulse_start();
        send_req(2'b00, 4'hE, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 4'd1, 24'h12, 1'b0);
        check("ill_err", 32'(err), 1);
        check("ill_state", 32'(state), 32'(ST_ERR));
        pulse_start();
        @(negedge clk);
        check("ill_clr_err", 32'(err), 0);
        check("ill_clr_count", 32'(count), 0);
        check("ill_clr_ready", 32'(in_ready), 1);

        // Illegal class
        send_req(2'b11, 4'hE, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd1, 24'h12, 1'b0);
        check("cls_err", 32'(err), 1);

        // Start aborts a pending write
        set_ready(1'b0);
        pulse_start();
        send_random(1'b0);
        pulse_start();
        @(negedge clk);
        check("abort_we", 32'(mem_we), 0);
        check("abort_count", 32'(count), 0);
        check("abort_addr", 32'(mem_addr), 0);
        check("abort_state", 32'(state), 32'(ST_RUN));

        // Randomized programs against the scoreboard
        for (int p = 0; p < 20; p++) begin
            rand_ready = 1'b1;
            pulse_start();
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) send_random(i == n - 1);
            wait_state(ST_DONE, 200);
            check("prog_done", 32'(done), 1);
            check("prog_count", 32'(count), 32'(n));
            check("prog_queue", 32'(exp_q.size()), 0);
        end

        // Reset asserted mid-write
        set_ready(1'b0);
        pulse_start();
        send_random(1'b0);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        exp_q.delete();
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("post_rst_state", 32'(state), 32'(ST_IDLE));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter: AW, default 6, instruction-memory address width; depth is 2**AW words.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle pulse; clears pointer and flags, enters RUN.
REQ-005 in_valid / in_ready  input / output  1 / 1  request handshake; transfer when both high at a clock edge.
REQ-006 in_class  input  2  00 data-processing, 01 memory, 10 branch, 11 illegal.
REQ-007 in_cond  input  4  condition field; in_aluop input 4 (0000 ADD, 0010 SUB, 0100 AND, 0101 ORR, 0110 EOR); in_s input 1; in_imm input 1 (I bit).
REQ-008 in_load, in_byte  input  1 each  L and B bits for memory class; in_rd, in_rn  input  4 each.
REQ-009 in_operand  input  24  DP: imm8 in [7:0] or Rm in [3:0]; memory: imm12 in [11:0]; branch: imm24.
REQ-010 in_last  input  1  marks final instruction of the program.
REQ-011 mem_we  output  1; mem_addr  output  AW; mem_wdata  output  32; mem_ready  input  1 (write completes when mem_we & mem_ready).
REQ-012 busy, done, err  output  1 each; count  output  AW+1  words written.

Function
REQ-013 States IDLE, RUN, DONE, ERR; start from any state goes to RUN next cycle; start has priority over all other events.
REQ-014 in_ready = (state==RUN) & ~start & (~mem_we | mem_ready) & ~(pointer full).
REQ-015 Latency: request accepted at edge N drives mem_we=1 with its word during cycle N+1; mem_we, mem_addr, mem_wdata held stable until mem_ready.
REQ-016 DP word: [31:28] cond, [27:26] 00, [25] in_imm, [24:21] cmd (ADD 0100, SUB 0010, AND 0000, ORR 1100, EOR 0001), [20] in_s, [19:16] Rn, [15:12] Rd, [11:0] in_imm ? {0000,imm8} : {00000000,Rm}.
REQ-017 Memory word: cond, 01, I=0, P=1, U=1, B=in_byte, W=0, L=in_load, Rn, Rd, imm12.
REQ-018 Branch word: cond, 10, 10 (no link), imm24.
REQ-019 Unsupported in_aluop for DP, or in_class 11, on an accepted request: no write, err=1, state ERR; err sticky until start or reset.
REQ-020 mem_addr = write pointer; pointer and count increment by 1 on each completed write.
REQ-021 Completion of the write at address 2**AW-1 without in_last: err=1, state ERR (overflow); with in_last: state DONE.
REQ-022 Completion of a write carrying in_last: state DONE, done=1 until start or reset.
REQ-023 start while a write is pending aborts it: mem_we=0 next cycle, pointer and count to 0.
REQ-024 busy = (state==RUN) | mem_we.

Reset
REQ-025 On reset low: state IDLE; mem_we 0, mem_addr 0, mem_wdata 0, count 0, in_ready 0, busy 0, done 0, err 0.
REQ-026 Reset asserted mid-write drops mem_we immediately (asynchronously); no partial state survives.

Structure
REQ-027 Shared package holds class codes, ALUControl codes, DP cmd codes, state encoding and field bit positions.
REQ-028 One combinational sub-module instr_pack (request fields -> 32-bit word plus illegal flag); FSM, pointer and output register in instr_encoder.

Verification
REQ-029 start; ADD cond 1110, S=1, I=1, Rn 1, Rd 2, imm8 0x05, in_last=1 -> cycle after accept mem_we=1, addr 0, wdata 0xE2912005; then done=1, count 1.
REQ-030 LDRB cond 1110, Rn 3, Rd 4, imm12 0x010 -> 0xE5D34010; STR same fields, in_load=0, in_byte=0 -> 0xE5834010.
REQ-031 Branch cond 0001, imm24 0xFFFFFE -> 0x1AFFFFFE; mem_ready low 3 cycles -> mem_we, addr, wdata stable, in_ready 0 throughout.
REQ-032 AW=2, 4 requests none in_last -> 4 writes at addr 0..3, then err=1, state ERR, in_ready 0.
REQ-033 in_aluop 1111 on DP request -> no mem_we, err=1; following start -> err 0, count 0, in_ready 1.
REQ-034 reset low during pending write with mem_ready low -> mem_we 0 same cycle, all outputs at reset values.
